// File: rtl/sync_counter_updn_pkg.sv
// Shared definitions for the up/down modulo counter family.
// Direction encoding, Gray conversion and modulus helpers.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int unsigned MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned max_count(input int unsigned modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/sync_counter_updn_dff_bank.sv
// WIDTH-bit D register with asynchronous active-high reset to zero.
module dff_bank #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else
            q <= d;
    end

endmodule

// File: rtl/sync_counter_updn.sv
// Parametrised modulo-N up/down counter with clear, load, wrap/tc flags
// and a registered Gray-coded copy of the count.
module sync_counter_updn
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned MODULUS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_gray,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (WIDTH < 2 || MODULUS < 2 ||
        longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
        $error("sync_counter_updn: MODULUS must lie in 2..2**WIDTH and WIDTH >= 2");
    end

    // Compare against MODULUS-1 so MODULUS == 2**WIDTH never overflows.
    localparam logic [WIDTH-1:0] MAXC = WIDTH'(max_count(MODULUS));

    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;
    logic             lerr_nxt;
    logic             at_end;

    assign at_end = (dir_e'(up) == DIR_UP) ? (q == MAXC) : (q == '0);
    assign tc     = en & ~clr & ~load & at_end;

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        lerr_nxt = 1'b0;
        if (clr) begin
            q_nxt = '0;
        end else if (load) begin
            if (load_val > MAXC) begin
                q_nxt    = '0;
                lerr_nxt = 1'b1;
            end else begin
                q_nxt = load_val;
            end
        end else if (en) begin
            wrap_nxt = at_end;
            if (dir_e'(up) == DIR_UP)
                q_nxt = at_end ? '0 : q + 1'b1;
            else
                q_nxt = at_end ? MAXC : q - 1'b1;
        end
    end

    // Gray is derived from the next value so it lands in the same edge as q.
    assign gray_nxt = WIDTH'(bin2gray(MAX_W'(q_nxt)));

    dff_bank #(.WIDTH(WIDTH)) u_q_reg (
        .clk   (clk),
        .reset (reset),
        .d     (q_nxt),
        .q     (q)
    );

    dff_bank #(.WIDTH(WIDTH)) u_gray_reg (
        .clk   (clk),
        .reset (reset),
        .d     (gray_nxt),
        .q     (q_gray)
    );

    dff_bank #(.WIDTH(1)) u_wrap_reg (
        .clk   (clk),
        .reset (reset),
        .d     (wrap_nxt),
        .q     (wrap)
    );

    dff_bank #(.WIDTH(1)) u_lerr_reg (
        .clk   (clk),
        .reset (reset),
        .d     (lerr_nxt),
        .q     (load_err)
    );

endmodule
